// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: datapath widths, op codes,
// and the request/response bundles carried between pipeline stages.
package alu_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned TAG_W = 4;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SLL = 3'd3;
    localparam logic [2:0] OP_SRA = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } alu_req_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             err;
        logic [TAG_W-1:0] tag;
    } alu_rsp_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle of the ALU execution unit.
// slave  : the execution unit (accepts requests, produces responses)
// master : the requester / consumer side
interface alu_exec_unit_if
    import alu_pkg::*;
();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_ovf;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_ovf, out_err, out_tag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_ovf, out_err, out_tag
    );

endinterface

// File: rtl/alu_func.sv
// Purely combinational ALU function evaluated between S1 and S2.
// Build option: define ALU_SHIFT_EN to enable op 3 (SLL) and op 4 (SRA);
// otherwise those codes take the illegal-op path.
module alu_func
    import alu_pkg::*;
(
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_ovf,
    output logic             o_err
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_lt   = ($signed(i_a) < $signed(i_b));

    // Select the result for the op; unknown codes report err with a zero result.
    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        o_err    = 1'b0;
        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_ADD: begin
                o_result = w_sum;
                // Same-sign operands whose sum flips sign overflowed.
                o_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result = w_diff;
                // Opposite-sign operands whose difference leaves a's sign overflowed.
                o_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
`ifdef ALU_SHIFT_EN
            OP_SLL: o_result = i_a << i_b[SHAMT_W-1:0];
            OP_SRA: o_result = $signed(i_a) >>> i_b[SHAMT_W-1:0];
`endif
            default: o_err = 1'b1;
        endcase
        o_zero = !o_err && (o_result == '0);
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage handshaked ALU execution unit.
// S1 holds the accepted request, S2 holds the computed response and drives
// the out_* ports directly. Full backpressure, one op per cycle, in order.
// Build option ALU_SHIFT_EN (handled inside alu_func) adds SLL/SRA.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    logic     r_s1_valid;
    alu_req_t r_s1_req;
    logic     r_out_valid;
    alu_rsp_t r_out_rsp;

    logic             w_adv2;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_ovf;
    logic             w_err;

    // S2 can take new data when empty or being drained this cycle; S1 can
    // accept when empty or moving into S2 on the same edge.
    assign w_adv2     = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_adv2;
    assign w_accept   = bus.in_valid && w_in_ready;

    alu_func u_alu_func (
        .i_op     (r_s1_req.op),
        .i_a      (r_s1_req.a),
        .i_b      (r_s1_req.b),
        .o_result (w_result),
        .o_zero   (w_zero),
        .o_ovf    (w_ovf),
        .o_err    (w_err)
    );

    // S1: capture a request on accept, otherwise empty once it has moved on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_req   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_req   <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: load the computed response when advancing; hold everything while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_rsp   <= '0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_rsp <= '{result: w_result, zero: w_zero, ovf: w_ovf,
                               err: w_err, tag: r_s1_req.tag};
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_rsp.result;
    assign bus.out_zero   = r_out_rsp.zero;
    assign bus.out_ovf    = r_out_rsp.ovf;
    assign bus.out_err    = r_out_rsp.err;
    assign bus.out_tag    = r_out_rsp.tag;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases followed by random
// traffic, checked against an arithmetic reference model and an in-order
// expected-response queue.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    alu_rsp_t expq[$];
    logic     acc_last   = 1'b0;
    logic     stall_prev = 1'b0;
    alu_rsp_t prev_obs   = '0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic alu_rsp_t ref_rsp(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] tag);
        alu_rsp_t x;
        int sa, sb, r;
        bit legal;
        logic [3:0] sh;
        x = '0; r = 0; legal = 1'b1;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[3:0];
        case (op)
            3'd0: r = int'(a & b);
            3'd1: r = int'(a | b);
            3'd2: begin r = sa + sb; x.ovf = (r > 32767) || (r < -32768); end
            3'd6: begin r = sa - sb; x.ovf = (r > 32767) || (r < -32768); end
            3'd7: r = (sa < sb) ? 1 : 0;
`ifdef ALU_SHIFT_EN
            3'd3: r = int'(a) * (1 << sh);
            3'd4: r = (sa >= 0) ? (sa / (1 << sh)) : -((-sa + (1 << sh) - 1) / (1 << sh));
`endif
            default: legal = 1'b0;
        endcase
        if (legal) x.result = r[15:0];
        x.err  = !legal;
        x.zero = legal && (x.result == 16'h0000);
        x.tag  = tag;
        return x;
    endfunction

    function automatic alu_rsp_t lit(input logic [15:0] res, input logic z, input logic o,
                                     input logic e, input logic [3:0] tag);
        alu_rsp_t x;
        x = '{result: res, zero: z, ovf: o, err: e, tag: tag};
        return x;
    endfunction

    // One cycle: drive inputs, check handshake and response just before the edge,
    // update the expected queue for what the coming edge does.
    task automatic step(input logic iv, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tag, input logic ordy,
                        input logic use_lit, input alu_rsp_t lit_rsp);
        alu_rsp_t obs, e;
        logic acc;
        int unsigned inflight;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        #1;
        inflight = expq.size();
        obs = '{result: bus.out_result, zero: bus.out_zero, ovf: bus.out_ovf,
                err: bus.out_err, tag: bus.out_tag};
        check("in_ready", 32'(bus.in_ready), 32'(!(inflight == 2 && !ordy)));
        check("out_valid", 32'(bus.out_valid),
              32'((inflight >= 1) && !(inflight == 1 && acc_last)));
        if (stall_prev) check("hold", 32'(obs), 32'(prev_obs));
        if (bus.out_valid && ordy) begin
            if (expq.size() == 0) begin
                check("spurious_rsp", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                check("result", 32'(obs.result), 32'(e.result));
                check("zero",   32'(obs.zero),   32'(e.zero));
                check("ovf",    32'(obs.ovf),    32'(e.ovf));
                check("err",    32'(obs.err),    32'(e.err));
                check("tag",    32'(obs.tag),    32'(e.tag));
            end
        end
        acc = iv && bus.in_ready;
        if (acc) expq.push_back(use_lit ? lit_rsp : ref_rsp(op, a, b, tag));
        acc_last   = acc;
        stall_prev = bus.out_valid && !ordy;
        prev_obs   = obs;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 16'h0, 16'h0, 4'h0, ordy, 1'b0, '0);
    endtask

    task automatic dir(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tag, input alu_rsp_t exp);
        step(1'b1, op, a, b, tag, 1'b1, 1'b1, exp);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_bus",   32'({bus.out_result, bus.out_zero, bus.out_ovf,
                                    bus.out_err, bus.out_tag}), 32'd0);
        rst = 1'b0;

        // Directed ALU cases, back-to-back with the consumer always ready
        dir(3'd2, 16'h7FFF, 16'h0001, 4'd3, lit(16'h8000, 1'b0, 1'b1, 1'b0, 4'd3));
        dir(3'd6, 16'h1234, 16'h1234, 4'd4, lit(16'h0000, 1'b1, 1'b0, 1'b0, 4'd4));
        dir(3'd6, 16'h8000, 16'h0001, 4'd5, lit(16'h7FFF, 1'b0, 1'b1, 1'b0, 4'd5));
        dir(3'd7, 16'hFFFB, 16'h0003, 4'd6, lit(16'h0001, 1'b0, 1'b0, 1'b0, 4'd6));
        dir(3'd7, 16'h0003, 16'hFFFB, 4'd7, lit(16'h0000, 1'b1, 1'b0, 1'b0, 4'd7));
        dir(3'd0, 16'hF0F0, 16'h0FF0, 4'd8, lit(16'h00F0, 1'b0, 1'b0, 1'b0, 4'd8));
        dir(3'd1, 16'hF0F0, 16'h0FF0, 4'd9, lit(16'hFFF0, 1'b0, 1'b0, 1'b0, 4'd9));
        dir(3'd5, 16'h1111, 16'h2222, 4'd10, lit(16'h0000, 1'b0, 1'b0, 1'b1, 4'd10));
`ifdef ALU_SHIFT_EN
        dir(3'd3, 16'h0001, 16'h0004, 4'd11, lit(16'h0010, 1'b0, 1'b0, 1'b0, 4'd11));
        dir(3'd4, 16'h8000, 16'h0004, 4'd12, lit(16'hF800, 1'b0, 1'b0, 1'b0, 4'd12));
`else
        dir(3'd3, 16'h0001, 16'h0004, 4'd11, lit(16'h0000, 1'b0, 1'b0, 1'b1, 4'd11));
        dir(3'd4, 16'h8000, 16'h0004, 4'd12, lit(16'h0000, 1'b0, 1'b0, 1'b1, 4'd12));
`endif
        idle(1'b1);
        idle(1'b1);
        check("drained_dir", 32'(expq.size()), 32'd0);

        // Backpressure: tags 1,2 accepted, 3 stalls until release
        step(1'b1, 3'd2, 16'd1, 16'd1, 4'd1, 1'b0, 1'b0, '0);
        step(1'b1, 3'd2, 16'd2, 16'd2, 4'd2, 1'b0, 1'b0, '0);
        step(1'b1, 3'd2, 16'd3, 16'd3, 4'd3, 1'b0, 1'b0, '0);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_head_tag", 32'(bus.out_tag), 32'd1);
        step(1'b1, 3'd2, 16'd3, 16'd3, 4'd3, 1'b0, 1'b0, '0);
        check("bp_hold_tag", 32'(bus.out_tag), 32'd1);
        step(1'b1, 3'd2, 16'd3, 16'd3, 4'd3, 1'b1, 1'b0, '0);
        check("bp_accept3", 32'(expq.size()), 32'd2);
        idle(1'b1);
        check("bp_second_tag", 32'(bus.out_tag), 32'd2);
        idle(1'b1);
        check("bp_third_tag", 32'(bus.out_tag), 32'd3);
        idle(1'b1);

        // Reset with both stages full
        step(1'b1, 3'd0, 16'hAAAA, 16'hFFFF, 4'd13, 1'b0, 1'b0, '0);
        step(1'b1, 3'd1, 16'h5555, 16'h0000, 4'd14, 1'b0, 1'b0, '0);
        idle(1'b0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
        expq.delete();
        acc_last   = 1'b0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick_operand(),
                 pick_operand(), 4'($urandom), ($urandom_range(0, 2) != 0), 1'b0, '0);
        end

        // Bounded drain
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("final_drain", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Handshaked, two-stage pipelined execution unit for the 16-bit datapath. It is the responder side of the ALU request interface. A requester issues {op, a, b, tag} over valid/ready. The unit returns {result, zero, ovf, err, tag} over valid/ready, in order, with full backpressure and a throughput of one operation per cycle. It sits between the instruction issue logic and writeback, and wraps the combinational ALU function in registered, flow-controlled stages.

## Interface
- WIDTH, 16, operand/result width (signed two's complement)
- TAG_W, 4, width of the requester tag carried through unchanged
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request this cycle
- in_op  in  3  operation code (encoding below)
- in_a, in_b  in  WIDTH  signed operands
- in_tag  in  TAG_W  request tag
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts response this cycle
- out_result  out  WIDTH  operation result
- out_zero  out  1  result == 0 (legal ops only)
- out_ovf  out  1  signed overflow (ADD/SUB only)
- out_err  out  1  unsupported op code
- out_tag  out  TAG_W  tag of the request that produced this response

## Operation
- Op codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed a<b gives 1, else 0). Codes 3, 4 and 5 are illegal unless enabled (see Configuration).
- ADD and SUB wrap modulo 2^WIDTH.
  - ovf=1 when the operand signs make the true result unrepresentable.
  - ovf=0 for all other ops.
- Illegal op: result=0, zero=0, ovf=0, err=1. The tag is still returned and ordering is preserved.
- Stage 1 (S1) registers the accepted request: op, a, b, tag and s1_valid.
- Stage 2 (S2) registers the computed response. The out_* ports are the S2 registers directly.
- Advance conditions:
  - adv2 = !out_valid || out_ready
  - in_ready = !s1_valid || adv2 (combinational from out_ready; no registered skid)
- Accept on in_valid && in_ready. S1 moves to S2 on s1_valid && adv2.
- When S2 empties while S1 is empty, out_valid drops on the next edge.
- While out_valid && !out_ready, every out_* port holds stable.
- Responses leave strictly in acceptance order. Nothing is dropped or duplicated except at reset.

## Timing
- Reset values: out_valid=0, out_result=0, out_zero=0, out_ovf=0, out_err=0, out_tag=0, s1_valid=0. in_ready=1 during and after reset.
- Latency: a request accepted at edge N gives out_valid=1 after edge N+1, provided out_ready was high or S2 was empty at N+1.
- Throughput: 1 per cycle with out_ready held high.
- Full condition: s1_valid && out_valid && !out_ready. In this state in_ready=0 and nothing changes.
- Simultaneous accept, advance and drain in the same cycle is legal. All three happen on the same edge.
- Reset asserted mid-operation clears s1_valid and out_valid immediately (asynchronously). In-flight requests are discarded and not replayed.
- in_* values are sampled only on the accept edge. Changes at other times are ignored.

## Configuration
- ALU_SHIFT_EN defined:
  - op 3 is SLL: a << b[3:0].
  - op 4 is SRA: arithmetic a >>> b[3:0].
  - Both produce ovf=0 and err=0, and zero is computed normally.
  - op 5 remains illegal.
- ALU_SHIFT_EN undefined: ops 3, 4 and 5 all take the illegal-op path (err=1).
- Pipeline timing is identical in both builds.

## Structure
- Package alu_pkg holds:
  - op code localparams: OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRA, OP_SUB, OP_SLT
  - alu_req_t struct: op, a, b, tag
  - alu_rsp_t struct: result, zero, ovf, err, tag
- Sub-module alu_func: purely combinational. It takes op, a and b, and returns result, zero, ovf and err. It is instantiated between S1 and S2. The ALU_SHIFT_EN guard lives inside alu_func.
- alu_exec_unit itself contains only the handshake, the S1/S2 registers and the tag pass-through.

## Test plan
- ADD: a=0x7FFF, b=0x0001, tag=3 -> result=0x8000, ovf=1, zero=0, err=0, tag=3, two edges after accept.
- SUB: a=b=0x1234 -> result=0, zero=1, ovf=0. Also SUB a=0x8000, b=1 -> result=0x7FFF, ovf=1.
- SLT: a=-5, b=3 -> result=1. Then a=3, b=-5 -> result=0, zero=1. AND 0xF0F0&0x0FF0 -> 0x00F0. OR -> 0xFFF0.
- Backpressure:
  - Stimulus: out_ready=0, offer tags 1, 2, 3 back-to-back.
  - Required: tags 1 and 2 accepted, then in_ready=0 and outputs hold tag 1.
  - Release out_ready=1 -> tags 1, 2, 3 emerge in order, one per cycle, and tag 3 is accepted on release.
- Op 5 -> err=1, result=0, zero=0. Op 3 with a=1, b=4:
  - ALU_SHIFT_EN defined -> result=0x0010.
  - ALU_SHIFT_EN undefined -> err=1.
- Assert rst with S1 and S2 both full -> out_valid=0 immediately, in_ready=1 after release, and no stale response appears afterwards.
